// File: rtl/crossbar_scheduler.sv
// Crossbar scheduler: per-output round-robin matching of input requests, held for a fixed slot.
// Optional CROSSBAR_SCHED_SHIFT_ONLY_EN restricts each slot's matching to a single rotation.
//
// state | meaning
// IDLE  | no slot in progress, waiting for any request
// ARB   | one cycle: matching computed, registered on exit
// CONN  | connections driven for SLOT_CYCLES cycles
module crossbar_scheduler #(
  parameter int N           = 8,
  parameter int SLOT_CYCLES = 4,
  localparam int W  = $clog2(N),
  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req_valid,
  input  logic [N-1:0][W-1:0] req_dst,
  output logic [N-1:0]        grant,
  output logic [N-1:0][W-1:0] input_sel,
  output logic [N-1:0]        output_enable,
  output logic                slot_active
);

  typedef enum logic [1:0] {IDLE, ARB, CONN} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       slot_cnt;
  logic                slot_last;
  logic [N-1:0][W-1:0] ptr;

  logic [N-1:0]        m_en;
  logic [N-1:0]        m_grant;
  logic [N-1:0][W-1:0] m_sel;
  logic [N-1:0]        taken;
  logic                found;
  logic                elig;
  logic [W-1:0]        idx;
`ifdef CROSSBAR_SCHED_SHIFT_ONLY_EN
  logic                anchored;
  logic [W-1:0]        shift_s;
`endif

  assign slot_last = (slot_cnt == CW'(SLOT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req_valid) state_nxt = ARB;
      ARB:     state_nxt = CONN;
      CONN:    if (slot_last) state_nxt = (|req_valid) ? ARB : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs claim inputs in ascending order; each scans from its own RR pointer.
  always_comb begin
    m_en    = '0;
    m_grant = '0;
    m_sel   = '0;
    taken   = '0;
    found   = 1'b0;
    elig    = 1'b0;
    idx     = '0;
`ifdef CROSSBAR_SCHED_SHIFT_ONLY_EN
    anchored = 1'b0;
    shift_s  = '0;
`endif
    for (int o = 0; o < N; o++) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        idx  = ptr[o] + W'(k);
        elig = 1'b1;
`ifdef CROSSBAR_SCHED_SHIFT_ONLY_EN
        elig = !anchored || ((W'(o) - idx) == shift_s);
`endif
        if (!found && req_valid[idx] && (req_dst[idx] == W'(o)) && !taken[idx] && elig) begin
          found        = 1'b1;
          taken[idx]   = 1'b1;
          m_en[o]      = 1'b1;
          m_sel[o]     = idx;
          m_grant[idx] = 1'b1;
`ifdef CROSSBAR_SCHED_SHIFT_ONLY_EN
          if (!anchored) begin
            anchored = 1'b1;
            shift_s  = W'(o) - idx;
          end
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant         <= '0;
      input_sel     <= '0;
      output_enable <= '0;
      slot_active   <= 1'b0;
      slot_cnt      <= '0;
      ptr           <= '0;
    end else begin
      grant <= '0;
      case (state)
        ARB: begin
          grant         <= m_grant;
          input_sel     <= m_sel;
          output_enable <= m_en;
          slot_active   <= 1'b1;
          slot_cnt      <= '0;
          for (int o = 0; o < N; o++) begin
            if (m_en[o]) ptr[o] <= m_sel[o] + W'(1);
          end
        end
        CONN: begin
          if (slot_last) begin
            slot_cnt      <= '0;
            output_enable <= '0;
            slot_active   <= 1'b0;
          end else begin
            slot_cnt <= slot_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crossbar_scheduler.sv
// Testbench for crossbar_scheduler: directed scenarios plus randomized request traffic
// checked slot by slot against a transaction-level round-robin matching model.
module tb_crossbar_scheduler;

  localparam int N  = 8;
  localparam int SC = 4;

  logic                clk;
  logic                rst_n;
  logic [N-1:0]        req_valid;
  logic [N-1:0][2:0]   req_dst;
  logic [N-1:0]        grant;
  logic [N-1:0][2:0]   input_sel;
  logic [N-1:0]        output_enable;
  logic                slot_active;

  int total = 0;
  int bad   = 0;
  int mptr[N];
  int add_left = 0;

  crossbar_scheduler #(.N(N), .SLOT_CYCLES(SC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_dst       (req_dst),
    .grant         (grant),
    .input_sel     (input_sel),
    .output_enable (output_enable),
    .slot_active   (slot_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: for each output in order, the pending request closest (cyclically) after
  // the output's pointer wins; in shift-only mode the first winner fixes the rotation.
  task automatic model_arb(output logic [N-1:0] eg, output logic [N-1:0] een,
                           output logic [N-1:0][2:0] esel);
    bit taken[N];
    int best, bestd, d;
    bit ok;
`ifdef CROSSBAR_SCHED_SHIFT_ONLY_EN
    bit anch;
    int s;
    anch = 0;
    s    = 0;
`endif
    eg = '0; een = '0; esel = '0;
    for (int i = 0; i < N; i++) taken[i] = 0;
    for (int o = 0; o < N; o++) begin
      best = -1; bestd = N;
      for (int i = 0; i < N; i++) begin
        d  = (i - mptr[o] + N) % N;
        ok = req_valid[i] && (int'(req_dst[i]) == o) && !taken[i];
`ifdef CROSSBAR_SCHED_SHIFT_ONLY_EN
        if (anch && ((o - i + N) % N) != s) ok = 0;
`endif
        if (ok && d < bestd) begin best = i; bestd = d; end
      end
      if (best >= 0) begin
        taken[best] = 1;
        eg[best]    = 1'b1;
        een[o]      = 1'b1;
        esel[o]     = 3'(best);
        mptr[o]     = (best + 1) % N;
`ifdef CROSSBAR_SCHED_SHIFT_ONLY_EN
        if (!anch) begin anch = 1; s = (o - best + N) % N; end
`endif
      end
    end
  endtask

  // drop: 0 hold requests, 1 drop granted inputs, 2 drop all requests after the grant
  task automatic do_slot(input bit from_idle, input int drop, output logic [N-1:0] g_obs,
                         output logic [N-1:0][2:0] sel_obs, output logic [N-1:0] en_obs);
    logic [N-1:0]      eg, een;
    logic [N-1:0][2:0] esel;
    if (from_idle) begin
      tick();
      chk("arb_en", 32'(output_enable), 32'h0);
      chk("arb_active", 32'(slot_active), 32'h0);
      chk("arb_grant", 32'(grant), 32'h0);
    end
    model_arb(eg, een, esel);
    tick();
    g_obs = grant; sel_obs = input_sel; en_obs = output_enable;
    chk("grant", 32'(grant), 32'(eg));
    chk("enable", 32'(output_enable), 32'(een));
    chk("sel", 32'(input_sel), 32'(esel));
    chk("active", 32'(slot_active), 32'h1);
    if (drop == 1) req_valid = req_valid & ~grant;
    if (drop == 2) req_valid = '0;
    for (int i = 0; i < N; i++) begin
      if (add_left > 0 && !req_valid[i] && $urandom_range(0, 3) == 0) begin
        req_valid[i] = 1'b1;
        req_dst[i]   = 3'($urandom_range(0, N - 1));
        add_left--;
      end
    end
    for (int c = 1; c < SC; c++) begin
      tick();
      chk("grant_pulse", 32'(grant), 32'h0);
      chk("hold_en", 32'(output_enable), 32'(een));
      chk("hold_sel", 32'(input_sel), 32'(esel));
      chk("hold_active", 32'(slot_active), 32'h1);
    end
    tick();
    chk("gap_en", 32'(output_enable), 32'h0);
    chk("gap_active", 32'(slot_active), 32'h0);
    chk("gap_grant", 32'(grant), 32'h0);
  endtask

  task automatic idle_check();
    tick();
    chk("idle_active", 32'(slot_active), 32'h0);
    chk("idle_en", 32'(output_enable), 32'h0);
  endtask

  task automatic run_until_idle(input int max_slots);
    logic [N-1:0]      g, en;
    logic [N-1:0][2:0] sel;
    int n;
    n = 0;
    do_slot(1'b1, 1, g, sel, en);
    while (|req_valid && n < max_slots) begin
      do_slot(1'b0, 1, g, sel, en);
      n++;
    end
    chk("slot_budget", 32'(req_valid), 32'h0);
    if (|req_valid) begin
      req_valid = '0;
      repeat (SC + 3) tick();
    end
    idle_check();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    chk("rst_grant", 32'(grant), 32'h0);
    tick();
    chk("rst_en", 32'(output_enable), 32'h0);
    chk("rst_active", 32'(slot_active), 32'h0);
    chk("rst_sel", 32'(input_sel), 32'h0);
    rst_n = 1'b1;
    for (int o = 0; o < N; o++) mptr[o] = 0;
  endtask

  initial begin
    logic [N-1:0]      g, en;
    logic [N-1:0][2:0] sel, exp_sel;

    // T1: reset with every input requesting, then release
    req_valid = '1;
    for (int i = 0; i < N; i++) req_dst[i] = 3'(i);
    do_reset();
    run_until_idle(4);

    // T2: full rotation
    req_valid = '1;
    for (int i = 0; i < N; i++) req_dst[i] = 3'((i + 1) % N);
    do_slot(1'b1, 1, g, sel, en);
    chk("t2_grant", 32'(g), 32'hFF);
    chk("t2_enable", 32'(en), 32'hFF);
    for (int o = 0; o < N; o++) exp_sel[o] = 3'((o + 7) % N);
    chk("t2_sel", 32'(sel), 32'(exp_sel));
    idle_check();

    // T3: inputs 2 and 5 contend for output 3
    req_valid = '0;
    do_reset();
    req_valid = 8'h24;
    req_dst[2] = 3'd3;
    req_dst[5] = 3'd3;
    do_slot(1'b1, 0, g, sel, en);
    chk("t3_slot1", 32'(g), 32'h04);
    chk("t3_sel1", 32'(sel[3]), 32'd2);
    do_slot(1'b0, 0, g, sel, en);
    chk("t3_slot2", 32'(g), 32'h20);
    chk("t3_sel2", 32'(sel[3]), 32'd5);
    do_slot(1'b0, 2, g, sel, en);
    chk("t3_slot3", 32'(g), 32'h04);
    idle_check();

    // T4: single request 6 -> 0
    req_valid = 8'h40;
    req_dst[6] = 3'd0;
    do_slot(1'b1, 1, g, sel, en);
    chk("t4_enable", 32'(en), 32'h01);
    exp_sel = '0;
    exp_sel[0] = 3'd6;
    chk("t4_sel", 32'(sel), 32'(exp_sel));
    idle_check();

    // T5: reset in the middle of a slot drops connections and pointers
    req_valid = 8'h02;
    req_dst[1] = 3'd3;
    tick();
    tick();
    chk("t5_grant", 32'(grant), 32'h02);
    req_valid = '0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("t5_rst_en", 32'(output_enable), 32'h0);
    chk("t5_rst_active", 32'(slot_active), 32'h0);
    chk("t5_rst_grant", 32'(grant), 32'h0);
    tick();
    rst_n = 1'b1;
    for (int o = 0; o < N; o++) mptr[o] = 0;
    req_valid = 8'h06;
    req_dst[1] = 3'd3;
    req_dst[2] = 3'd3;
    do_slot(1'b1, 1, g, sel, en);
    chk("t5_ptr_reset", 32'(g), 32'h02);
    do_slot(1'b0, 1, g, sel, en);
    chk("t5_next", 32'(g), 32'h04);
    idle_check();

    // T6: three-cycle map 0->1, 1->2, 2->0
    req_valid = '0;
    do_reset();
    req_valid = 8'h07;
    req_dst[0] = 3'd1;
    req_dst[1] = 3'd2;
    req_dst[2] = 3'd0;
    do_slot(1'b1, 1, g, sel, en);
`ifdef CROSSBAR_SCHED_SHIFT_ONLY_EN
    chk("t6_shift_slot1", 32'(g), 32'h04);
`else
    chk("t6_full_slot1", 32'(g), 32'h07);
`endif
    while (|req_valid) do_slot(1'b0, 1, g, sel, en);
    idle_check();

    // Randomized traffic with occasional new requests arriving during slots
    for (int r = 0; r < 10; r++) begin
      req_valid = 8'($urandom_range(1, 255));
      for (int i = 0; i < N; i++) req_dst[i] = 3'($urandom_range(0, N - 1));
      add_left = 6;
      run_until_idle(40);
      add_left = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
